// File: rtl/pkg_en.sv
// Shared ElectronNest types for the external-memory port: flow tokens, command record and FSM states.
// The FTk .i index field only carries data when LD_INDEX_EN is defined.
package pkg_en;

    localparam int WIDTH_EXADDR      = 16;
    localparam int WIDTH_DATA        = 32;
    localparam int WIDTH_INDEX       = 16;
    localparam int WIDTH_LEN_MAX     = 32;
    localparam int LD_FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic                   v;
        logic                   a;
        logic                   r;
        logic                   c;
        logic [WIDTH_INDEX-1:0] i;
        logic [WIDTH_DATA-1:0]  d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef struct packed {
        logic                     st;
        logic [WIDTH_EXADDR-1:0]  base;
        logic [WIDTH_LEN_MAX-1:0] len;
    } mem_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LDRAIN,
        STORE,
        DONE
    } fsm_mem_port_t;

    // Word address of a burst element; wraps modulo 2^WIDTH_EXADDR.
    function automatic logic [WIDTH_EXADDR-1:0] addr_offset(
        input logic [WIDTH_EXADDR-1:0]  base,
        input logic [WIDTH_LEN_MAX-1:0] off
    );
        return base + off[WIDTH_EXADDR-1:0];
    endfunction

endpackage

// File: rtl/ext_mem_ld_fifo.sv
// Synchronous FIFO of FTk_t tokens buffering load responses before they enter the array.
// DEPTH must be a power of two; head reads as all-zero when the FIFO is empty.
module ext_mem_ld_fifo
    import pkg_en::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  FTk_t                     push_tok,
    input  logic                     pop,
    output FTk_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    FTk_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tok;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ext_mem_port_ctrl.sv
// Initiator for the ElectronNest external-memory load/store interface (loads stream into the array, stores stream out).
// Define LD_INDEX_EN to carry the burst word offset in the FTk .i field.
module ext_mem_port_ctrl
    import pkg_en::*;
#(
    parameter int LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEF,
    parameter int WIDTH_LEN     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Cmd_Valid,
    input  logic                    I_Cmd_St,
    input  logic [WIDTH_EXADDR-1:0] I_Cmd_Base,
    input  logic [WIDTH_LEN-1:0]    I_Cmd_Len,
    output logic                    O_Cmd_Ready,
    output logic                    O_Done,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  FTk_t                    I_Ld_FTk,
    output BTk_t                    O_Ld_BTk,
    output FTk_t                    O_FTk,
    input  BTk_t                    I_BTk,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output FTk_t                    O_St_FTk,
    input  BTk_t                    I_St_BTk
);

    localparam int CW = $clog2(LD_FIFO_DEPTH) + 1;

    fsm_mem_port_t           state;
    mem_cmd_t                cmd_in;
    logic [WIDTH_EXADDR-1:0] base_q;
    logic [WIDTH_LEN-1:0]    len_q;
    logic [WIDTH_LEN-1:0]    issued;
    logic [WIDTH_LEN-1:0]    committed;
    logic                    inflight;
    logic [WIDTH_LEN-1:0]    inflight_off;
    logic                    cmd_ready_q;
    logic                    done_q;
    logic                    ld_req;
    logic                    ld_ret;
    logic                    ld_pop;
    FTk_t                    push_tok;
    FTk_t                    fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    FTk_t                    st_reg;
    FTk_t                    st_tok_in;
    logic                    st_commit;
    logic                    st_take;
    logic                    arr_stall;
    logic                    unused_bits;

    assign cmd_in = '{st: I_Cmd_St, base: I_Cmd_Base, len: WIDTH_LEN_MAX'(I_Cmd_Len)};

    // Credit counts the response still on the wire so a return can always be pushed.
    assign ld_req    = (state == LOAD) && (issued < len_q)
                       && ((CW'(inflight) + fifo_count) < CW'(LD_FIFO_DEPTH));
    assign ld_ret    = inflight & I_Ld_FTk.v;
    assign ld_pop    = ~fifo_empty & ~I_BTk.n;
    assign st_commit = st_reg.v & ~I_St_BTk.n;
    assign st_take   = (state == STORE) & I_FTk.v & ~arr_stall;

    always_comb begin
        push_tok   = '0;
        push_tok.v = 1'b1;
        push_tok.a = (inflight_off == '0);
        push_tok.r = (inflight_off == len_q - WIDTH_LEN'(1));
        push_tok.d = I_Ld_FTk.d;
`ifdef LD_INDEX_EN
        push_tok.i = WIDTH_INDEX'(inflight_off);
`endif
        st_tok_in = I_FTk;
`ifndef LD_INDEX_EN
        st_tok_in.i = '0;
`endif
    end

    always_comb begin
        arr_stall = 1'b0;
        case (state)
            STORE:              arr_stall = (st_reg.v & I_St_BTk.n)
                                            | ((committed + WIDTH_LEN'(st_reg.v)) == len_q);
            LOAD, LDRAIN, DONE: arr_stall = 1'b1;
            default:            arr_stall = 1'b0;
        endcase
    end

    ext_mem_ld_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (ld_ret),
        .push_tok (push_tok),
        .pop      (ld_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign O_Cmd_Ready = cmd_ready_q;
    assign O_Done      = done_q;
    assign O_Ld_Req    = ld_req;
    assign O_Ld_Addr   = ld_req ? addr_offset(base_q, WIDTH_LEN_MAX'(issued)) : '0;
    assign O_Ld_BTk    = '{n: fifo_full, t: 1'b0, v: 1'b0, c: 1'b0};
    assign O_FTk       = fifo_head;
    assign O_BTk       = '{n: arr_stall, t: 1'b0, v: 1'b0, c: 1'b0};
    assign O_St_Req    = st_reg.v;
    assign O_St_FTk    = st_reg;
    assign O_St_Addr   = st_reg.v ? addr_offset(base_q, WIDTH_LEN_MAX'(committed)) : '0;
    assign unused_bits = ^{cmd_in, I_Ld_FTk, I_BTk, I_FTk, I_St_BTk};

    // Ready and Done are registered so both read 0 while reset is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            issued       <= '0;
            committed    <= '0;
            inflight     <= 1'b0;
            inflight_off <= '0;
            st_reg       <= '0;
            cmd_ready_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inflight    <= ld_req;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            if (ld_req) begin
                inflight_off <= issued;
                issued       <= issued + WIDTH_LEN'(1);
            end
            if (st_commit) begin
                committed <= committed + WIDTH_LEN'(1);
            end
            if (st_take) begin
                st_reg <= st_tok_in;
            end else if (st_commit) begin
                st_reg <= '0;
            end
            case (state)
                IDLE: begin
                    if (I_Cmd_Valid && cmd_ready_q) begin
                        base_q    <= cmd_in.base;
                        len_q     <= I_Cmd_Len;
                        issued    <= '0;
                        committed <= '0;
                        if (I_Cmd_Len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= cmd_in.st ? STORE : LOAD;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (issued == len_q) begin
                        state <= LDRAIN;
                    end
                end
                LDRAIN: begin
                    if (fifo_empty && !inflight) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                STORE: begin
                    if (committed == len_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_port_ctrl.sv
// Directed self-checking bench for ext_mem_port_ctrl with a 1-cycle-latency load memory and a store memory model.
// Honours LD_INDEX_EN when checking the FTk .i field.
module tb_ext_mem_port_ctrl;
    import pkg_en::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        I_Cmd_Valid = 1'b0;
    logic        I_Cmd_St = 1'b0;
    logic [15:0] I_Cmd_Base = '0;
    logic [15:0] I_Cmd_Len = '0;
    logic        O_Cmd_Ready;
    logic        O_Done;
    logic        O_Ld_Req;
    logic [15:0] O_Ld_Addr;
    FTk_t        I_Ld_FTk = '0;
    BTk_t        O_Ld_BTk;
    FTk_t        O_FTk;
    BTk_t        I_BTk = '0;
    FTk_t        I_FTk = '0;
    BTk_t        O_BTk;
    logic        O_St_Req;
    logic [15:0] O_St_Addr;
    FTk_t        O_St_FTk;
    BTk_t        I_St_BTk = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    FTk_t        words[$];
    logic [15:0] req_addrs[$];
    int          req_cycs[$];
    int          out_cnt = 0;
    int          max_out = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          wr_total = 0;
    int          wr_count[int];
    logic [31:0] wr_data[int];
    logic [15:0] wr_idx[int];
    int          stall_cnt = 0;
    int          mirror_cnt = 0;
    int          stall_target = 0;

    always #5 clock = ~clock;

    ext_mem_port_ctrl #(
        .LD_FIFO_DEPTH (4),
        .WIDTH_LEN     (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Cmd_Valid (I_Cmd_Valid),
        .I_Cmd_St    (I_Cmd_St),
        .I_Cmd_Base  (I_Cmd_Base),
        .I_Cmd_Len   (I_Cmd_Len),
        .O_Cmd_Ready (O_Cmd_Ready),
        .O_Done      (O_Done),
        .O_Ld_Req    (O_Ld_Req),
        .O_Ld_Addr   (O_Ld_Addr),
        .I_Ld_FTk    (I_Ld_FTk),
        .O_Ld_BTk    (O_Ld_BTk),
        .O_FTk       (O_FTk),
        .I_BTk       (I_BTk),
        .I_FTk       (I_FTk),
        .O_BTk       (O_BTk),
        .O_St_Req    (O_St_Req),
        .O_St_Addr   (O_St_Addr),
        .O_St_FTk    (O_St_FTk),
        .I_St_BTk    (I_St_BTk)
    );

    function automatic logic [31:0] memData(input logic [15:0] a);
        return 32'hD000_0000 | {16'h0000, a};
    endfunction

    function automatic BTk_t mkBtk(input logic n);
        BTk_t b;
        b   = '0;
        b.n = n;
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory responder plus observers of every handshake on the DUT boundary.
    always @(posedge clock) begin : monitor
        FTk_t rsp;
        rsp = '0;
        if (O_Ld_Req) begin
            rsp.v = 1'b1;
            rsp.d = memData(O_Ld_Addr);
            req_addrs.push_back(O_Ld_Addr);
            req_cycs.push_back(cyc);
            out_cnt++;
        end
        I_Ld_FTk <= rsp;
        if (O_FTk.v && !I_BTk.n) begin
            words.push_back(O_FTk);
            out_cnt--;
        end
        if (!reset) out_cnt = 0;
        if (out_cnt > max_out) max_out = out_cnt;
        if (O_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (O_St_Req && O_St_FTk.v && !I_St_BTk.n) begin
            wr_total++;
            wr_count[int'(O_St_Addr)] = (wr_count.exists(int'(O_St_Addr)) ? wr_count[int'(O_St_Addr)] : 0) + 1;
            wr_data[int'(O_St_Addr)]  = O_St_FTk.d;
            wr_idx[int'(O_St_Addr)]   = O_St_FTk.i;
        end
        if (O_St_Req && I_St_BTk.n) begin
            stall_cnt++;
            if (O_BTk.n) mirror_cnt++;
        end
        cyc++;
    end

    // Store memory refuses address 0x21 until the requested number of stall cycles has elapsed.
    always @(negedge clock) begin
        I_St_BTk = mkBtk((stall_cnt < stall_target) && O_St_Req && (O_St_Addr == 16'h0021));
    end

    task automatic applyStimulus(input logic st, input logic [15:0] base, input logic [15:0] len);
        int n;
        n = 0;
        @(negedge clock);
        I_Cmd_Valid = 1'b1;
        I_Cmd_St    = st;
        I_Cmd_Base  = base;
        I_Cmd_Len   = len;
        while (!O_Cmd_Ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("cmd_accept", 64'(n < 50), 64'd1);
        @(negedge clock);
        I_Cmd_Valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n;
        n = 0;
        while (!O_Done && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 64'(n < limit), 64'd1);
        @(negedge clock);
    endtask

    task automatic checkLoad(input string tag, input logic [15:0] base, input int len, input int wb, input int rb);
        FTk_t        w;
        logic [15:0] ea;
        logic [15:0] ei;
        checkOutput({tag, "_nreq"}, 64'(req_addrs.size() - rb), 64'(len));
        checkOutput({tag, "_nword"}, 64'(words.size() - wb), 64'(len));
        for (int k = 0; k < len; k++) begin
            ea = base + 16'(k);
`ifdef LD_INDEX_EN
            ei = 16'(k);
`else
            ei = '0;
`endif
            if (rb + k < req_addrs.size()) checkOutput({tag, "_addr"}, 64'(req_addrs[rb + k]), 64'(ea));
            if (wb + k < words.size()) begin
                w = words[wb + k];
                checkOutput({tag, "_data"}, 64'(w.d), 64'(memData(ea)));
                checkOutput({tag, "_a"}, 64'(w.a), 64'(k == 0));
                checkOutput({tag, "_r"}, 64'(w.r), 64'(k == len - 1));
                checkOutput({tag, "_c"}, 64'(w.c), 64'd0);
                checkOutput({tag, "_i"}, 64'(w.i), 64'(ei));
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ld_req"}, 64'(O_Ld_Req), 64'd0);
        checkOutput({tag, "_ld_addr"}, 64'(O_Ld_Addr), 64'd0);
        checkOutput({tag, "_ftk"}, 64'(O_FTk), 64'd0);
        checkOutput({tag, "_ld_btk"}, 64'(O_Ld_BTk), 64'd0);
        checkOutput({tag, "_btk"}, 64'(O_BTk), 64'd0);
        checkOutput({tag, "_st_req"}, 64'(O_St_Req), 64'd0);
        checkOutput({tag, "_st_ftk"}, 64'(O_St_FTk), 64'd0);
        checkOutput({tag, "_ready"}, 64'(O_Cmd_Ready), 64'd0);
        checkOutput({tag, "_done"}, 64'(O_Done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wb, rb, dc, rq, wt, sc, mc, n;
        logic [15:0] ei;
        FTk_t tok;

        #1 reset = 1'b0;
        #10;
        checkIdleOutputs("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("ready_after_reset", 64'(O_Cmd_Ready), 64'd1);

        // Load Base=0x10 Len=5, array never stalls.
        wb = words.size(); rb = req_addrs.size(); dc = done_cnt;
        applyStimulus(1'b0, 16'h0010, 16'd5);
        waitDone("ld5_done", 100);
        checkLoad("ld5", 16'h0010, 5, wb, rb);
        if (req_cycs.size() >= rb + 5) begin
            checkOutput("ld5_back_to_back", 64'(req_cycs[rb + 4] - req_cycs[rb]), 64'd4);
            n = done_cyc - req_cycs[rb + 4];
            checkOutput("ld5_done_latency", 64'(n >= 2 && n <= 6), 64'd1);
        end
        checkOutput("ld5_done_once", 64'(done_cnt - dc), 64'd1);
        checkOutput("ld5_ready_back", 64'(O_Cmd_Ready), 64'd1);

        // Load Len=8 with the array stalled for 6 cycles.
        wb = words.size(); rb = req_addrs.size();
        applyStimulus(1'b0, 16'h0200, 16'd8);
        I_BTk = mkBtk(1'b1);
        repeat (6) @(negedge clock);
        I_BTk = mkBtk(1'b0);
        waitDone("ld8_done", 200);
        checkLoad("ld8", 16'h0200, 8, wb, rb);
        checkOutput("ld8_max_outstanding_le4", 64'(max_out <= 4), 64'd1);

        // Store Base=0x20 Len=3, memory stalls the 2nd word for 2 cycles.
        sc = stall_cnt; mc = mirror_cnt; dc = done_cnt;
        stall_target = stall_cnt + 2;
        applyStimulus(1'b1, 16'h0020, 16'd3);
        for (int k = 0; k < 3; k++) begin
            tok   = '0;
            tok.v = 1'b1;
            tok.d = 32'hC0DE_0000 + 32'(k);
            tok.i = 16'(k + 7);
            I_FTk = tok;
            n = 0;
            #1;
            while (O_BTk.n && n < 40) begin
                @(negedge clock);
                #1;
                n++;
            end
            checkOutput("st_take", 64'(n < 40), 64'd1);
            @(negedge clock);
        end
        tok.d = 32'h0000_0BAD;
        I_FTk = tok;
        #1;
        checkOutput("st_excess_refused", 64'(O_BTk.n), 64'd1);
        I_FTk = '0;
        waitDone("st3_done", 100);
        for (int k = 0; k < 3; k++) begin
`ifdef LD_INDEX_EN
            ei = 16'(k + 7);
`else
            ei = '0;
`endif
            checkOutput("st3_wr_once", 64'(wr_count.exists(32 + k) ? wr_count[32 + k] : 0), 64'd1);
            checkOutput("st3_wr_data", 64'(wr_data.exists(32 + k) ? wr_data[32 + k] : 32'hFFFF_FFFF), 64'(32'hC0DE_0000 + 32'(k)));
            checkOutput("st3_wr_idx", 64'(wr_idx.exists(32 + k) ? wr_idx[32 + k] : 16'hFFFF), 64'(ei));
        end
        checkOutput("st3_no_excess_write", 64'(wr_count.exists(35) ? wr_count[35] : 0), 64'd0);
        checkOutput("st3_stall_cycles", 64'(stall_cnt - sc), 64'd2);
        checkOutput("st3_btk_mirrors_stall", 64'(mirror_cnt - mc), 64'd2);
        checkOutput("st3_done_once", 64'(done_cnt - dc), 64'd1);

        // Len=0 in both directions.
        rq = req_addrs.size(); wt = wr_total;
        applyStimulus(1'b0, 16'h0055, 16'd0);
        checkOutput("len0_ld_done", 64'(O_Done), 64'd1);
        @(negedge clock);
        checkOutput("len0_ld_done_pulse", 64'(O_Done), 64'd0);
        checkOutput("len0_ld_ready", 64'(O_Cmd_Ready), 64'd1);
        applyStimulus(1'b1, 16'h0066, 16'd0);
        checkOutput("len0_st_done", 64'(O_Done), 64'd1);
        @(negedge clock);
        checkOutput("len0_st_done_pulse", 64'(O_Done), 64'd0);
        checkOutput("len0_no_ld_req", 64'(req_addrs.size() - rq), 64'd0);
        checkOutput("len0_no_st_req", 64'(wr_total - wt), 64'd0);

        // Address wrap at the top of the address space.
        wb = words.size(); rb = req_addrs.size();
        applyStimulus(1'b0, 16'hFFFE, 16'd4);
        waitDone("wrap_done", 100);
        checkLoad("wrap", 16'hFFFE, 4, wb, rb);

        // Asynchronous reset in the middle of a stalled load burst.
        dc = done_cnt;
        applyStimulus(1'b0, 16'h0100, 16'd8);
        I_BTk = mkBtk(1'b1);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        repeat (2) @(negedge clock);
        I_BTk = mkBtk(1'b0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_no_done", 64'(done_cnt - dc), 64'd0);

        // Clean load after the abort: Base=0x40 Len=3.
        wb = words.size(); rb = req_addrs.size();
        applyStimulus(1'b0, 16'h0040, 16'd3);
        waitDone("post_rst_done", 100);
        checkLoad("post_rst", 16'h0040, 3, wb, rb);
        checkOutput("final_max_outstanding_le4", 64'(max_out <= 4), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
